// File: rtl/cvmcu_dbg_req_ctrl.sv
// Multi-hart debug request controller.
// Holds a debug request to each hart until that hart enters debug mode, and
// flags a sticky timeout if the hart never responds. Halt groups fan one
// request out to every group member. stoptimer_o covers any hart in debug
// mode plus a programmable hold after it resumes.
//
// Ports:
//   clk               clock, all state on rising edge
//   reset             asynchronous active-high reset
//   debug_req_i       level debug request per hart from the debug module
//   halt_group_i      halt-group membership mask, sampled each cycle
//   hart_halted_i     per-hart "in debug mode" status
//   clr_timeout_i     clears all timeout_o bits
//   hart_debug_req_o  debug request to each core
//   timeout_o         sticky per-hart request timeout flag
//   stoptimer_o       stop system timer while any hart is halted or in hold
module cvmcu_dbg_req_ctrl #(
    parameter int unsigned NUM_HARTS   = 4,
    parameter int unsigned REQ_TIMEOUT = 256,
    parameter int unsigned STOP_HOLD   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_HARTS-1:0] debug_req_i,
    input  logic [NUM_HARTS-1:0] halt_group_i,
    input  logic [NUM_HARTS-1:0] hart_halted_i,
    input  logic                 clr_timeout_i,
    output logic [NUM_HARTS-1:0] hart_debug_req_o,
    output logic [NUM_HARTS-1:0] timeout_o,
    output logic                 stoptimer_o
);

    localparam int unsigned CNT_MAX    = (REQ_TIMEOUT > STOP_HOLD) ? REQ_TIMEOUT : STOP_HOLD;
    localparam int unsigned CNT_W      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam bit          TIMEOUT_EN = (REQ_TIMEOUT != 0);
    localparam bit          HOLD_EN    = (STOP_HOLD != 0);
    // Guarded so a disabled timeout never produces a wrapped constant.
    localparam int unsigned TO_LAST    = TIMEOUT_EN ? (REQ_TIMEOUT - 1) : 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HALTED = 2'd2,
        ST_RESUME = 2'd3
    } state_e;

    logic                 grp_hit;
    logic [NUM_HARTS-1:0] eff_req;
    logic [NUM_HARTS-1:0] stop_vec;

    // Any requested group member pulls in every other member of the group.
    assign grp_hit     = |(debug_req_i & halt_group_i);
    assign eff_req     = debug_req_i | (halt_group_i & {NUM_HARTS{grp_hit}});
    assign stoptimer_o = |stop_vec;

    for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             timeout_q;
        logic             to_hit;

        // Final pending cycle; halt in the same cycle takes precedence.
        assign to_hit = TIMEOUT_EN && (state_q == ST_REQ) && !hart_halted_i[i]
                        && (cnt_q == CNT_W'(TO_LAST));

        // Per-hart request FSM with shared timeout/hold counter.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                timeout_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (hart_halted_i[i]) begin
                            state_q <= ST_HALTED;
                        end else if (eff_req[i]) begin
                            state_q <= ST_REQ;
                            cnt_q   <= '0;
                        end
                    end
                    ST_REQ: begin
                        if (hart_halted_i[i]) begin
                            state_q <= ST_HALTED;
                        end else if (to_hit) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_HALTED: begin
                        if (!hart_halted_i[i]) begin
                            if (HOLD_EN) begin
                                state_q <= ST_RESUME;
                                cnt_q   <= CNT_W'(STOP_HOLD);
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_RESUME: begin
                        if (hart_halted_i[i]) begin
                            state_q <= ST_HALTED;
                        end else if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase

                // Setting beats a simultaneous clear.
                if (to_hit) begin
                    timeout_q <= 1'b1;
                end else if (clr_timeout_i) begin
                    timeout_q <= 1'b0;
                end
            end
        end

        assign hart_debug_req_o[i] = (state_q == ST_REQ);
        assign timeout_o[i]        = timeout_q;
        assign stop_vec[i]         = (state_q == ST_HALTED) || (state_q == ST_RESUME);
    end

endmodule

// File: tb/tb_cvmcu_dbg_req_ctrl.sv
// Directed bench for cvmcu_dbg_req_ctrl (4 harts, timeout 16, hold 8).
module tb_cvmcu_dbg_req_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] debug_req_i;
    logic [3:0] halt_group_i;
    logic [3:0] hart_halted_i;
    logic       clr_timeout_i;
    logic [3:0] hart_debug_req_o;
    logic [3:0] timeout_o;
    logic       stoptimer_o;

    int n_vec;
    int n_err;

    cvmcu_dbg_req_ctrl #(
        .NUM_HARTS  (4),
        .REQ_TIMEOUT(16),
        .STOP_HOLD  (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .debug_req_i     (debug_req_i),
        .halt_group_i    (halt_group_i),
        .hart_halted_i   (hart_halted_i),
        .clr_timeout_i   (clr_timeout_i),
        .hart_debug_req_o(hart_debug_req_o),
        .timeout_o       (timeout_o),
        .stoptimer_o     (stoptimer_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        debug_req_i = '0; halt_group_i = '0; hart_halted_i = '0; clr_timeout_i = 1'b0;
        ticks(2);
        n_vec++;
        if (hart_debug_req_o !== 4'b0000) begin n_err++; $display("FAIL reset_req got=%b exp=0000", hart_debug_req_o); end
        n_vec++;
        if (timeout_o !== 4'b0000) begin n_err++; $display("FAIL reset_timeout got=%b exp=0000", timeout_o); end
        n_vec++;
        if (stoptimer_o !== 1'b0) begin n_err++; $display("FAIL reset_stop got=%b exp=0", stoptimer_o); end
        reset = 1'b0;
        tick();
    endtask

    // Single request on hart 2, halted 5 cycles later, then hold of 8 cycles.
    task automatic test_single();
        debug_req_i = 4'b0100;
        tick();
        debug_req_i = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (hart_debug_req_o !== 4'b0100 || stoptimer_o !== 1'b0) begin
                n_err++; $display("FAIL single_req k=%0d got=%b/%b exp=0100/0", k, hart_debug_req_o, stoptimer_o);
            end
            if (k < 4) tick();
        end
        hart_halted_i = 4'b0100;
        tick();
        n_vec++;
        if (hart_debug_req_o !== 4'b0000 || stoptimer_o !== 1'b1) begin
            n_err++; $display("FAIL single_halt got=%b/%b exp=0000/1", hart_debug_req_o, stoptimer_o);
        end
        tick();
        hart_halted_i = 4'b0000;  // resume driven at cycle T
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_vec++;
            if (stoptimer_o !== (k < 9)) begin
                n_err++; $display("FAIL single_hold T+%0d got=%b exp=%b", k, stoptimer_o, (k < 9));
            end
        end
        n_vec++;
        if (timeout_o !== 4'b0000) begin n_err++; $display("FAIL single_timeout got=%b exp=0000", timeout_o); end
    endtask

    task automatic test_halt_group();
        halt_group_i = 4'b1011;
        debug_req_i  = 4'b0001;
        tick();
        n_vec++;
        if (hart_debug_req_o !== 4'b1011) begin n_err++; $display("FAIL group_req got=%b exp=1011", hart_debug_req_o); end
        debug_req_i  = 4'b0000;
        halt_group_i = 4'b0000;
        hart_halted_i = 4'b1011;
        tick();
        n_vec++;
        if (hart_debug_req_o !== 4'b0000 || stoptimer_o !== 1'b1) begin
            n_err++; $display("FAIL group_halt got=%b/%b exp=0000/1", hart_debug_req_o, stoptimer_o);
        end
        hart_halted_i = 4'b0000;
        ticks(10);
        n_vec++;
        if (stoptimer_o !== 1'b0) begin n_err++; $display("FAIL group_release got=%b exp=0", stoptimer_o); end
    endtask

    task automatic test_timeout();
        int cnt;
        debug_req_i = 4'b0001;
        tick();
        debug_req_i = 4'b0000;
        cnt = 0;
        for (int k = 0; k < 40 && hart_debug_req_o[0]; k++) begin
            cnt++;
            tick();
        end
        n_vec++;
        if (cnt !== 16) begin n_err++; $display("FAIL timeout_len got=%0d exp=16", cnt); end
        n_vec++;
        if (timeout_o !== 4'b0001) begin n_err++; $display("FAIL timeout_set got=%b exp=0001", timeout_o); end
        ticks(3);
        n_vec++;
        if (timeout_o !== 4'b0001) begin n_err++; $display("FAIL timeout_sticky got=%b exp=0001", timeout_o); end
        clr_timeout_i = 1'b1;
        tick();
        clr_timeout_i = 1'b0;
        n_vec++;
        if (timeout_o !== 4'b0000) begin n_err++; $display("FAIL timeout_clr got=%b exp=0000", timeout_o); end
        // Clear pulse lands on the final pending edge: set wins.
        debug_req_i = 4'b0001;
        tick();
        debug_req_i = 4'b0000;
        ticks(15);
        clr_timeout_i = 1'b1;
        tick();
        clr_timeout_i = 1'b0;
        n_vec++;
        if (timeout_o !== 4'b0001 || hart_debug_req_o !== 4'b0000) begin
            n_err++; $display("FAIL timeout_set_vs_clr got=%b/%b exp=0001/0000", timeout_o, hart_debug_req_o);
        end
        clr_timeout_i = 1'b1;
        tick();
        clr_timeout_i = 1'b0;
    endtask

    // Hart 1 re-halts during the hold window; stoptimer must not drop.
    task automatic test_rehalt();
        bit dropped;
        hart_halted_i = 4'b0010;
        tick();
        tick();
        hart_halted_i = 4'b0000;
        dropped = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) hart_halted_i = 4'b0010;
            tick();
            if (!stoptimer_o) dropped = 1'b1;
        end
        ticks(10);
        if (!stoptimer_o) dropped = 1'b1;
        n_vec++;
        if (dropped) begin n_err++; $display("FAIL rehalt_stop got=drop exp=held"); end
        hart_halted_i = 4'b0000;
        ticks(10);
        n_vec++;
        if (stoptimer_o !== 1'b0) begin n_err++; $display("FAIL rehalt_release got=%b exp=0", stoptimer_o); end
    endtask

    task automatic test_self_halt();
        bit req_seen;
        hart_halted_i = 4'b1000;
        req_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (hart_debug_req_o[3]) req_seen = 1'b1;
        end
        n_vec++;
        if (req_seen || stoptimer_o !== 1'b1) begin
            n_err++; $display("FAIL self_halt got=req%b/stop%b exp=req0/stop1", req_seen, stoptimer_o);
        end
        hart_halted_i = 4'b0000;
        ticks(10);
        // Halt arrives exactly on the final pending edge: no timeout.
        debug_req_i = 4'b0001;
        tick();
        debug_req_i = 4'b0000;
        ticks(15);
        hart_halted_i = 4'b0001;
        tick();
        n_vec++;
        if (timeout_o !== 4'b0000 || hart_debug_req_o !== 4'b0000 || stoptimer_o !== 1'b1) begin
            n_err++; $display("FAIL halt_vs_timeout got=%b/%b/%b exp=0000/0000/1", timeout_o, hart_debug_req_o, stoptimer_o);
        end
        hart_halted_i = 4'b0000;
        ticks(10);
    endtask

    task automatic test_reset_mid();
        hart_halted_i = 4'b0010;
        debug_req_i   = 4'b0001;
        tick();
        debug_req_i   = 4'b0000;
        hart_halted_i = 4'b0000;
        tick();  // hart 0 in REQ, hart 1 in RESUME
        n_vec++;
        if (hart_debug_req_o !== 4'b0001 || stoptimer_o !== 1'b1) begin
            n_err++; $display("FAIL pre_reset got=%b/%b exp=0001/1", hart_debug_req_o, stoptimer_o);
        end
        reset = 1'b1;
        #1;  // well before the next clock edge
        n_vec++;
        if (hart_debug_req_o !== 4'b0000 || timeout_o !== 4'b0000 || stoptimer_o !== 1'b0) begin
            n_err++; $display("FAIL async_reset got=%b/%b/%b exp=0000/0000/0", hart_debug_req_o, timeout_o, stoptimer_o);
        end
        tick();
        reset = 1'b0;
        tick();
        debug_req_i = 4'b0010;
        tick();
        debug_req_i = 4'b0000;
        n_vec++;
        if (hart_debug_req_o !== 4'b0010 || stoptimer_o !== 1'b0) begin
            n_err++; $display("FAIL post_reset_req got=%b/%b exp=0010/0", hart_debug_req_o, stoptimer_o);
        end
        ticks(16);
        n_vec++;
        if (timeout_o !== 4'b0010 || hart_debug_req_o !== 4'b0000) begin
            n_err++; $display("FAIL post_reset_timeout got=%b/%b exp=0010/0000", timeout_o, hart_debug_req_o);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_halt_group();
        test_timeout();
        test_rehalt();
        test_self_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
